// File: rtl/prm_edge_pkg.sv
// prm_edge_pkg: shared widths and state encoding for the PRM edge query sequencer
package prm_edge_pkg;
  localparam int CODE_W  = 15;
  localparam int STEPS_W = 5;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/prm_code_stepper.sv
// prm_code_stepper: chk_code register with load of a base code and modulo-2^W step by delta
//   clk, rst_n : clock, async active-low reset (code clears to 0)
//   load, base : load code with base (load has priority over step)
//   step, delta: advance code by delta, wrapping silently
//   code       : current code word
module prm_code_stepper #(
  parameter int W = prm_edge_pkg::CODE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] base,
  input  logic [W-1:0] delta,
  output logic [W-1:0] code
);
  import prm_edge_pkg::*;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) code <= '0;
    else if (load) code <= base;
    else if (step) code <= code + delta;
endmodule

// File: rtl/prm_edge_query_seq.sv
// prm_edge_query_seq: walks an edge as base + k*delta codes through an external checker and reports hits
//   req_*   : query handshake (base code, delta, sample count); req_ready high only in IDLE
//   abort   : cancels a query in SCAN or DONE, no result is produced
//   chk_*   : code driven to the combinational checker and its returned mask
//   res_*   : result handshake; collide, first hit index, hit count held stable until res_ready
//   Build option PRM_EDGE_EARLY_EXIT_EN: stop scanning after the first hit.
module prm_edge_query_seq #(
  parameter int CODE_W  = prm_edge_pkg::CODE_W,
  parameter int STEPS_W = prm_edge_pkg::STEPS_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [CODE_W-1:0]  req_base,
  input  logic [CODE_W-1:0]  req_delta,
  input  logic [STEPS_W-1:0] req_steps,
  input  logic               abort,
  output logic [CODE_W-1:0]  chk_code,
  output logic               chk_valid,
  input  logic               chk_mask,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_collide,
  output logic [STEPS_W-1:0] res_first_idx,
  output logic [STEPS_W-1:0] res_hit_count
);
  import prm_edge_pkg::*;
  state_t state, nstate;
  logic [CODE_W-1:0] delta_q;
  logic [STEPS_W-1:0] steps_q, idx;
  logic take, last, stop;
  assign take = state == IDLE && req_valid;
  assign last = idx == steps_q - STEPS_W'(1);
`ifdef PRM_EDGE_EARLY_EXIT_EN
  assign stop = last || chk_mask;
`else
  assign stop = last;
`endif
  prm_code_stepper #(.W(CODE_W)) u_stepper (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (take && req_steps != '0),
    .step  (state == SCAN),
    .base  (req_base),
    .delta (delta_q),
    .code  (chk_code)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nstate;
  always_comb begin
    nstate = state;
    req_ready = 1'b0;
    chk_valid = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) nstate = req_steps != '0 ? SCAN : DONE;
      end
      SCAN: begin
        chk_valid = 1'b1;
        nstate = abort ? IDLE : stop ? DONE : SCAN;
      end
      DONE: begin
        res_valid = 1'b1;
        nstate = (abort || res_ready) ? IDLE : DONE;
      end
      default: nstate = IDLE;
    endcase
  end
  // first_idx is recorded only while collide is still clear, i.e. on the first hit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      delta_q <= '0;
      steps_q <= '0;
      idx <= '0;
      res_collide <= 1'b0;
      res_first_idx <= '0;
      res_hit_count <= '0;
    end else if (take) begin
      delta_q <= req_delta;
      steps_q <= req_steps;
      idx <= '0;
      res_collide <= 1'b0;
      res_first_idx <= '0;
      res_hit_count <= '0;
    end else if (state == SCAN) begin
      idx <= idx + STEPS_W'(1);
      if (chk_mask) begin
        res_collide <= 1'b1;
        res_hit_count <= res_hit_count + STEPS_W'(1);
        if (!res_collide) res_first_idx <= idx;
      end
    end
endmodule

// File: tb/tb_prm_edge_query_seq.sv
// tb_prm_edge_query_seq: randomized queries against a transaction-level model of the edge sequencer
module tb_prm_edge_query_seq;
  localparam int CW = 15;
  localparam int SW = 5;
`ifdef PRM_EDGE_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, abort = 1'b0, res_ready = 1'b0;
  logic req_ready, chk_valid, chk_mask, res_valid, res_collide;
  logic [CW-1:0] req_base = '0, req_delta = '0, chk_code;
  logic [SW-1:0] req_steps = '0, res_first_idx, res_hit_count;
  bit obst [32768];
  typedef struct {
    bit rdy; bit cv; bit care; logic [CW-1:0] code;
    bit rv; bit rcare; bit col; logic [SW-1:0] fi; logic [SW-1:0] hc;
  } exp_t;
  exp_t exp_q[$];
  logic [CW-1:0] obs_codes[$];
  logic obs_col = 1'b0;
  logic [SW-1:0] obs_fi = '0, obs_hc = '0;
  int checks = 0, fails = 0, cyc = 0, rv_first = -1, t0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign chk_mask = obst[chk_code];

  prm_edge_query_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_delta(req_delta), .req_steps(req_steps), .abort(abort),
    .chk_code(chk_code), .chk_valid(chk_valid), .chk_mask(chk_mask),
    .res_valid(res_valid), .res_ready(res_ready), .res_collide(res_collide),
    .res_first_idx(res_first_idx), .res_hit_count(res_hit_count)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", n, a, e, cyc);
    end
  endtask

  function automatic exp_t mk(input bit rdy, input bit cv, input bit care, input logic [CW-1:0] code,
                              input bit rv, input bit rcare, input bit col,
                              input logic [SW-1:0] fi, input logic [SW-1:0] hc);
    exp_t e;
    e.rdy = rdy; e.cv = cv; e.care = care; e.code = code;
    e.rv = rv; e.rcare = rcare; e.col = col; e.fi = fi; e.hc = hc;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("req_ready", 32'(req_ready), 32'(e.rdy));
      chk("chk_valid", 32'(chk_valid), 32'(e.cv));
      chk("res_valid", 32'(res_valid), 32'(e.rv));
      if (e.care) chk("chk_code", 32'(chk_code), 32'(e.code));
      if (e.rcare) begin
        chk("res_collide", 32'(res_collide), 32'(e.col));
        chk("res_first_idx", 32'(res_first_idx), 32'(e.fi));
        chk("res_hit_count", 32'(res_hit_count), 32'(e.hc));
      end
    end
    if (chk_valid) obs_codes.push_back(chk_code);
    if (res_valid) begin
      obs_col = res_collide;
      obs_fi = res_first_idx;
      obs_hc = res_hit_count;
      if (rv_first < 0) rv_first = cyc;
    end
  end

  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      req_valid = 1'b0;
      abort = 1'($urandom);
      res_ready = 1'($urandom);
      step(mk(1, 0, 0, '0, 0, 0, 0, '0, '0));
    end
    abort = 1'b0;
    res_ready = 1'b0;
  endtask

  // One query: cycle 0 offers it, samples k appear in cycle k+1, result after the scan,
  // held for 'hold' extra cycles. ab/rs give the cycle of an abort / reset pulse (0 = none).
  task automatic run_q(input logic [CW-1:0] b, input logic [CW-1:0] d, input int n,
                       input int hold, input int ab, input int rs);
    int l, first, hc;
    logic [CW-1:0] cd;
    l = n; first = -1; hc = 0;
    for (int k = 0; k < n; k++) begin
      cd = b + d * CW'(k);
      if (obst[cd]) begin
        if (first < 0) first = k;
        hc++;
        if (EARLY) begin
          l = k + 1;
          break;
        end
      end
    end
    req_valid = 1'b1; req_base = b; req_delta = d; req_steps = SW'(n);
    abort = 1'($urandom);
    res_ready = 1'($urandom);
    step(mk(1, 0, 0, '0, 0, 0, 0, '0, '0));
    for (int c = 1; c <= l + hold + 1; c++) begin
      if (c == rs) begin
        rst_n = 1'b0; req_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
        step(mk(1, 0, 1, '0, 0, 1, 0, '0, '0));
        rst_n = 1'b1;
        return;
      end
      abort = (c == ab);
      req_valid = 1'($urandom); req_base = CW'($urandom); req_delta = CW'($urandom); req_steps = SW'($urandom);
      res_ready = (c <= l) ? 1'($urandom) : (c == l + hold + 1);
      if (c <= l) step(mk(0, 1, 1, b + d * CW'(c - 1), 0, 0, 0, '0, '0));
      else step(mk(0, 0, 0, '0, 1, 1, first >= 0, SW'(first < 0 ? 0 : first), SW'(hc)));
      if (c == ab) break;
    end
    req_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
  endtask

  initial begin
    logic [CW-1:0] wrap_exp [3];
    int n, hold, ab, rs;
    wrap_exp[0] = 15'h7FFE; wrap_exp[1] = 15'h0000; wrap_exp[2] = 15'h0002;
    @(posedge clk);
    #1;
    step(mk(1, 0, 1, '0, 0, 1, 0, '0, '0));
    step(mk(1, 0, 1, '0, 0, 1, 0, '0, '0));
    rst_n = 1'b1;
    idle(2);
    // linear walk, no obstacles
    obs_codes.delete(); rv_first = -1; t0 = cyc;
    run_q(15'h0000, 15'h0001, 4, 0, 0, 0);
    chk("walk_ncodes", obs_codes.size(), 4);
    for (int i = 0; i < 4; i++) chk("walk_code", 32'(obs_codes[i]), i);
    chk("walk_latency", rv_first - t0, 5);
    chk("walk_collide", 32'(obs_col), 0);
    chk("walk_count", 32'(obs_hc), 0);
    // hits at indices 2 and 4
    obst[15'h30] = 1'b1; obst[15'h50] = 1'b1;
    obs_codes.delete();
    run_q(15'h0010, 15'h0010, 6, 2, 0, 0);
    chk("hits_first", 32'(obs_fi), 2);
    chk("hits_count", 32'(obs_hc), EARLY ? 1 : 2);
    chk("hits_nsamples", obs_codes.size(), EARLY ? 3 : 6);
    obst[15'h30] = 1'b0; obst[15'h50] = 1'b0;
    // code wrap
    obs_codes.delete();
    run_q(15'h7FFE, 15'h0002, 3, 1, 0, 0);
    chk("wrap_ncodes", obs_codes.size(), 3);
    for (int i = 0; i < 3; i++) chk("wrap_code", 32'(obs_codes[i]), 32'(wrap_exp[i]));
    // zero-step query
    obs_codes.delete(); rv_first = -1; t0 = cyc;
    run_q(15'h0123, 15'h0005, 0, 2, 0, 0);
    chk("zero_ncodes", obs_codes.size(), 0);
    chk("zero_latency", rv_first - t0, 1);
    // long hold, abort / reset at index 1, abort and reset in DONE
    run_q(15'h0000, 15'h0001, 3, 5, 0, 0);
    run_q(15'h0000, 15'h0001, 4, 0, 2, 0);
    idle(1);
    run_q(15'h0040, 15'h0003, 3, 0, 0, 0);
    run_q(15'h0000, 15'h0001, 4, 0, 0, 2);
    run_q(15'h0040, 15'h0003, 3, 0, 0, 0);
    run_q(15'h0000, 15'h0001, 2, 3, 4, 0);
    run_q(15'h0000, 15'h0001, 2, 1, 4, 0);
    run_q(15'h0000, 15'h0001, 2, 3, 0, 4);
    // random obstacle field and queries
    for (int i = 0; i < 32768; i++) obst[i] = ($urandom_range(0, 7) == 0);
    repeat (200) begin
      n = $urandom_range(0, 31);
      hold = $urandom_range(0, 4);
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, n + hold + 1) : 0;
      rs = ($urandom_range(0, 11) == 0) ? $urandom_range(1, n + hold + 1) : 0;
      run_q(CW'($urandom), CW'($urandom), n, hold, ab, rs);
      idle($urandom_range(0, 2));
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/prm_edge_query_seq.md
PRM_EDGE_QUERY_SEQ -- requirements
Module: prm_edge_query_seq

Interface
REQ-001 Parameter CODE_W, default 15, width of one obstacle-check code word; bit 0 maps to checker input A, bit 14 to input O.
REQ-002 Parameter STEPS_W, default 5, width of the sample-count and index fields, giving at most 31 samples per edge.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  edge query offered.
REQ-006 req_ready  output  1  sequencer can accept a query.
REQ-007 req_base  input  CODE_W  code of the first sample.
REQ-008 req_delta  input  CODE_W  code increment between samples.
REQ-009 req_steps  input  STEPS_W  number of samples to check.
REQ-010 abort  input  1  cancel the query in progress.
REQ-011 chk_code  output  CODE_W  code driven to the combinational edge checker.
REQ-012 chk_valid  output  1  chk_code is a live sample.
REQ-013 chk_mask  input  1  checker edge_mask for the current chk_code.
REQ-014 res_valid  output  1  result available.
REQ-015 res_ready  input  1  consumer accepts the result.
REQ-016 res_collide  output  1  at least one sample returned mask=1.
REQ-017 res_first_idx  output  STEPS_W  index of the first hit; 0 when there is no hit.
REQ-018 res_hit_count  output  STEPS_W  number of hits among the scanned samples.

Function
REQ-019 The state machine SHALL have states IDLE, SCAN and DONE, with req_ready=1 only in IDLE.
REQ-020 IDLE transitions: on req_valid&req_ready with req_steps>0, capture the fields, load chk_code=req_base, clear the counters, and enter SCAN; with req_steps=0, enter DONE with collide=0 and count=0.
REQ-021 SCAN behaviour: chk_valid=1; each cycle, sample chk_mask for the held chk_code, then advance chk_code by req_delta modulo 2^CODE_W and increment the index.
REQ-022 A hit updates: on chk_mask=1, set collide, increment hit_count, and record first_idx if this is the first hit.
REQ-023 SCAN exit: leave for DONE after the sample at index req_steps-1 (or earlier per REQ-031); chk_valid=0 outside SCAN.
REQ-024 Latency: a query accepted at cycle 0 with N samples and no early exit presents index k in cycle k+1, and res_valid rises in cycle N+1.
REQ-025 DONE behaviour: hold res_valid=1 and all res_* stable until res_ready=1, then return to IDLE in the next cycle; no new query is accepted while in DONE.
REQ-026 abort=1 in SCAN or DONE returns to IDLE next cycle, with no result and res_valid=0; abort has no effect in IDLE.
REQ-027 If abort and res_ready coincide in DONE, abort wins; the result is treated as discarded.
REQ-028 chk_code wraps silently through 2^CODE_W; hit_count saturation is impossible because it is bounded by req_steps.

Reset
REQ-029 Reset values, applied asynchronously while rst_n=0 with release synchronous to clk: state=IDLE, req_ready=1, chk_code=0, chk_valid=0, res_valid=0, res_collide=0, res_first_idx=0, res_hit_count=0.
REQ-030 Reset asserted mid-SCAN discards the query; no result is emitted after release.

Configuration
REQ-031 With PRM_EDGE_EARLY_EXIT_EN defined, SCAN exits to DONE in the cycle after the first hit, so hit_count=1; without it, every sample is scanned and hit_count counts all hits.

Structure
REQ-032 Package prm_edge_pkg SHALL hold CODE_W, STEPS_W and the state enum type.
REQ-033 Sub-module prm_code_stepper SHALL hold the chk_code register and the modulo adder, with load and step controls.

Verification
REQ-034 Base 0x0000, delta 0x0001, steps 4, mask tied 0 -> chk_code 0,1,2,3 in cycles 1-4; res_valid in cycle 5 with collide=0, count=0.
REQ-035 Base 0x0010, delta 0x0010, steps 6, mask=1 at indices 2 and 4 -> with the macro: DONE after index 2, first_idx=2, count=1; without: first_idx=2, count=2.
REQ-036 Base 0x7FFE, delta 0x0002, steps 3 -> chk_code 0x7FFE, 0x0000, 0x0002, showing the wrap.
REQ-037 steps=0 -> res_valid in cycle 1 with collide=0, and chk_valid never asserts.
REQ-038 res_ready held 0 for 5 cycles in DONE -> outputs stable, req_ready=0; res_ready=1 -> IDLE next cycle.
REQ-039 abort, or rst_n low, in the cycle of index 1 -> IDLE, res_valid stays 0, and a new query is accepted.
